// File: rtl/pipe_pkg.sv
// Constants shared by the fetch, decode and execute stages: opcodes, NOP and the branch counter type.
package pipe_pkg;

    localparam int          PC_W_DEFAULT = 16;
    localparam logic [3:0]  OP_J         = 4'b1100;
    localparam logic [3:0]  OP_BRC       = 4'b1101;
    localparam logic [15:0] NOP          = 16'h0000;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_ctr_t;

    // Saturating 2-bit counter step: never wraps past SNT or ST.
    function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken && (ctr != ST)) begin
            nxt = bht_ctr_t'(ctr + 2'd1);
        end else if (!taken && (ctr != SNT)) begin
            nxt = bht_ctr_t'(ctr - 2'd1);
        end
        return nxt;
    endfunction

    function automatic logic bht_predict_taken(input bht_ctr_t ctr);
        return (ctr >= WT);
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit branch counters: combinational lookup, registered saturating update.
module branch_history_table
    import pipe_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_ctr_t ctr_q [DEPTH];

    // Read is taken from the current register value, so a same-cycle update is not visible yet.
    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= bht_ctr_next(ctr_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, branch prediction and IF/ID output register.
// Dynamic BRC prediction via the branch history table is built only when IF_BHT_EN is defined.
module instruction_fetch
    import pipe_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEFAULT,
    parameter int              BHT_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] IMEM_ADDR,
    input  logic [15:0]     IMEM_RDATA,
    input  logic            STALL_IF,
    input  logic            BR_RESOLVE_VALID,
    input  logic [PC_W-1:0] BR_RESOLVE_PC,
    input  logic            BR_RESOLVE_TAKEN,
    input  logic            BR_RESOLVE_PRED,
    input  logic [PC_W-1:0] BR_RESOLVE_TARGET,
    output logic [PC_W-1:0] NPC_IF,
    output logic [15:0]     INST_IF,
    output logic            BRANCH_PRED
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] fetch_target;
    logic [PC_W-1:0] resolve_next;
    logic [3:0]      opcode;
    logic            brc_taken;
    logic            pred_taken;
    logic            mispredict;

    if ((BHT_DEPTH < 2) || ((BHT_DEPTH & (BHT_DEPTH - 1)) != 0)) begin : g_bad_bht_depth
        $error("BHT_DEPTH must be a power of two of at least 2");
    end

    assign IMEM_ADDR    = pc;
    assign pc_plus1     = pc + 1'b1;
    assign opcode       = IMEM_RDATA[15:12];
    assign fetch_target = PC_W'(IMEM_RDATA[11:0]);
    assign mispredict   = BR_RESOLVE_VALID && (BR_RESOLVE_TAKEN != BR_RESOLVE_PRED);
    assign resolve_next = BR_RESOLVE_TAKEN ? BR_RESOLVE_TARGET : (BR_RESOLVE_PC + 1'b1);

`ifdef IF_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    bht_ctr_t lookup_ctr;

    // Every resolution trains the table, jumps included, even while IF is stalled.
    branch_history_table #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc[IDX_W-1:0]),
        .rd_ctr    (lookup_ctr),
        .upd_en    (BR_RESOLVE_VALID),
        .upd_idx   (BR_RESOLVE_PC[IDX_W-1:0]),
        .upd_taken (BR_RESOLVE_TAKEN)
    );

    assign brc_taken = bht_predict_taken(lookup_ctr);
`else
    assign brc_taken = 1'b0;
`endif

    assign pred_taken = (opcode == OP_J) || ((opcode == OP_BRC) && brc_taken);

    // A mispredict outranks the stall so the wrong-path fetch is never held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            INST_IF     <= NOP;
            NPC_IF      <= '0;
            BRANCH_PRED <= 1'b0;
        end else if (mispredict) begin
            pc          <= resolve_next;
            INST_IF     <= NOP;
            NPC_IF      <= '0;
            BRANCH_PRED <= 1'b0;
        end else if (!STALL_IF) begin
            pc          <= pred_taken ? fetch_target : pc_plus1;
            INST_IF     <= IMEM_RDATA;
            NPC_IF      <= pc_plus1;
            BRANCH_PRED <= pred_taken;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: reference model feeds a scoreboard of expected IF/ID outputs.
module tb_instruction_fetch;

`ifdef IF_BHT_EN
    localparam bit BHT_EN = 1'b1;
`else
    localparam bit BHT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] IMEM_ADDR;
    logic [15:0] IMEM_RDATA;
    logic        STALL_IF = 1'b0;
    logic        BR_RESOLVE_VALID = 1'b0;
    logic [15:0] BR_RESOLVE_PC = '0;
    logic        BR_RESOLVE_TAKEN = 1'b0;
    logic        BR_RESOLVE_PRED = 1'b0;
    logic [15:0] BR_RESOLVE_TARGET = '0;
    logic [15:0] NPC_IF;
    logic [15:0] INST_IF;
    logic        BRANCH_PRED;

    logic [15:0] mem [0:65535];

    assign IMEM_RDATA = mem[IMEM_ADDR];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .IMEM_ADDR         (IMEM_ADDR),
        .IMEM_RDATA        (IMEM_RDATA),
        .STALL_IF          (STALL_IF),
        .BR_RESOLVE_VALID  (BR_RESOLVE_VALID),
        .BR_RESOLVE_PC     (BR_RESOLVE_PC),
        .BR_RESOLVE_TAKEN  (BR_RESOLVE_TAKEN),
        .BR_RESOLVE_PRED   (BR_RESOLVE_PRED),
        .BR_RESOLVE_TARGET (BR_RESOLVE_TARGET),
        .NPC_IF            (NPC_IF),
        .INST_IF           (INST_IF),
        .BRANCH_PRED       (BRANCH_PRED)
    );

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] npc;
        logic        pred;
    } exp_t;

    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] m_pc;
    logic [15:0] m_inst;
    logic [15:0] m_npc;
    logic        m_pred;
    logic [1:0]  m_bht [16];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    // Reference behaviour for one clock, evaluated with the inputs of that clock.
    task automatic model_step(input logic r, input logic s, input logic rv, input logic [15:0] rpc,
                              input logic rt, input logic rp, input logic [15:0] rtgt);
        logic [15:0] w;
        logic [3:0]  op;
        logic        pt;
        logic [15:0] nxt;
        w  = mem[m_pc];
        op = w[15:12];
        pt = (op == 4'hC) || ((op == 4'hD) && BHT_EN && (m_bht[m_pc[3:0]] >= 2'd2));
        if (r) begin
            m_pc   = 16'h0000;
            m_inst = 16'h0000;
            m_npc  = 16'h0000;
            m_pred = 1'b0;
            for (int i = 0; i < 16; i++) m_bht[i] = 2'd1;
        end else begin
            if (rv) begin
                if (rt && m_bht[rpc[3:0]] != 2'd3) m_bht[rpc[3:0]] = m_bht[rpc[3:0]] + 2'd1;
                else if (!rt && m_bht[rpc[3:0]] != 2'd0) m_bht[rpc[3:0]] = m_bht[rpc[3:0]] - 2'd1;
            end
            if (rv && (rt != rp)) begin
                nxt    = rpc + 16'd1;
                m_pc   = rt ? rtgt : nxt;
                m_inst = 16'h0000;
                m_npc  = 16'h0000;
                m_pred = 1'b0;
            end else if (!s) begin
                nxt    = m_pc + 16'd1;
                m_inst = w;
                m_npc  = nxt;
                m_pred = pt;
                m_pc   = pt ? {4'h0, w[11:0]} : nxt;
            end
        end
        sb_q.push_back('{inst: m_inst, npc: m_npc, pred: m_pred});
    endtask

    task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rpc,
                        input logic rt, input logic rp, input logic [15:0] rtgt);
        exp_t e;
        rst               = r;
        STALL_IF          = s;
        BR_RESOLVE_VALID  = rv;
        BR_RESOLVE_PC     = rpc;
        BR_RESOLVE_TAKEN  = rt;
        BR_RESOLVE_PRED   = rp;
        BR_RESOLVE_TARGET = rtgt;
        #1;
        if (!r) check("imem_addr", IMEM_ADDR, m_pc);
        model_step(r, s, rv, rpc, rt, rp, rtgt);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("inst_if", INST_IF, e.inst);
        check("npc_if", NPC_IF, e.npc);
        check("branch_pred", BRANCH_PRED, e.pred);
    endtask

    task automatic tick(input logic s);
        step(1'b0, s, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic resolve(input logic s, input logic [15:0] rpc, input logic rt, input logic rp,
                           input logic [15:0] rtgt);
        step(1'b0, s, 1'b1, rpc, rt, rp, rtgt);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int a = 6; a < 32; a++) mem[a] = 16'h1000 | 16'(a);
        for (int a = 16'h40; a < 16'h50; a++) mem[a] = 16'h2000 | 16'(a);
        for (int a = 16'h123; a < 16'h130; a++) mem[a] = 16'h3000 | 16'(a);
        mem[4]       = 16'hD040;
        mem[5]       = 16'hC123;
        mem[20]      = 16'hD00A;
        mem[16'hFFFF] = 16'h1234;

        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check("reset_addr", IMEM_ADDR, 16'h0000);

        for (int i = 0; i < 4; i++) tick(1'b0);
        check("seq_npc", NPC_IF, 16'h0004);

        tick(1'b0);
        check("brc_fresh_nt", BRANCH_PRED, 1'b0);
        tick(1'b0);
        check("j_addr", IMEM_ADDR, 16'h0123);
        check("j_inst", INST_IF, 16'hC123);
        check("j_npc", NPC_IF, 16'h0006);
        check("j_pred", BRANCH_PRED, 1'b1);

        resolve(1'b0, 16'h4, 1'b1, 1'b0, 16'h0040);
        check("redirect_taken", IMEM_ADDR, 16'h0040);
        resolve(1'b0, 16'h4, 1'b1, 1'b1, 16'h0040);
        resolve(1'b0, 16'h3, 1'b0, 1'b1, 16'h0000);
        tick(1'b0);
        check("brc_trained", BRANCH_PRED, BHT_EN);

        // Third taken resolve must saturate; the following same-cycle lookup still sees strong-taken.
        resolve(1'b0, 16'h4, 1'b1, 1'b1, 16'h0040);
        resolve(1'b0, 16'h3, 1'b0, 1'b1, 16'h0000);
        resolve(1'b0, 16'h4, 1'b0, 1'b0, 16'h0000);
        check("brc_saturated", BRANCH_PRED, BHT_EN);
        resolve(1'b0, 16'h3, 1'b0, 1'b1, 16'h0000);
        resolve(1'b0, 16'h4, 1'b0, 1'b0, 16'h0000);
        check("brc_wt_lookup", BRANCH_PRED, BHT_EN);
        resolve(1'b0, 16'h3, 1'b0, 1'b1, 16'h0000);
        tick(1'b0);
        check("brc_back_nt", BRANCH_PRED, 1'b0);

        resolve(1'b0, 16'h3, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) tick(1'b0);
        resolve(1'b1, 16'h8, 1'b0, 1'b1, 16'h0000);
        check("stall_flush_addr", IMEM_ADDR, 16'h0009);
        check("stall_flush_inst", INST_IF, 16'h0000);
        check("stall_flush_pred", BRANCH_PRED, 1'b0);

        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("stall_hold_addr", IMEM_ADDR, 16'h000B);
        check("stall_hold_inst", INST_IF, 16'h100A);
        tick(1'b0);
        check("stall_release", NPC_IF, 16'h000C);

        resolve(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF);
        tick(1'b0);
        check("wrap_addr", IMEM_ADDR, 16'h0000);
        check("wrap_npc", NPC_IF, 16'h0000);
        check("wrap_inst", INST_IF, 16'h1234);

        tick(1'b0);
        tick(1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check("rst_stall_addr", IMEM_ADDR, 16'h0000);
        check("rst_stall_inst", INST_IF, 16'h0000);

        for (int i = 0; i < 80; i++) begin
            step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 16'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
